vip_stream_decoder: RTL
=======================

// Module: vip_stream_decoder
// PURPOSE
//  Avalon-ST Video sink front-end for the pixel-filter cores. Parses incoming packets:
//  - control packets (type 0xF) -> width/height/interlaced, with a one-cycle update strobe
//  - video packets (type 0x0)   -> flow-controlled pixel stream with end-of-video flag
//  - other packet types         -> discarded
//  Sits between the video input port and the core's stall/read interface (core sees stall, data, end_of_video).
// PARAMETERS
//  BITS_PER_SYMBOL   8   bits per colour symbol (>=4)
//  SYMBOLS_PER_BEAT  3   symbols per beat, parallel; supported values 1, 2, 3
// PORTS
//  clk                 in   1        clock
//  rst                 in   1        reset, asynchronous, active-high
//  din_data            in   B*S      Avalon-ST data; symbol 0 in LSBs
//  din_valid           in   1        source beat valid
//  din_startofpacket   in   1        first beat of packet (header beat)
//  din_endofpacket     in   1        last beat of packet
//  din_ready           out  1        sink ready, ready latency 0
//  read                in   1        core accepts pixel when read & ~stall
//  stall               out  1        1 = no pixel available to core
//  data_out            out  B*S      pixel to core
//  end_of_video        out  1        data_out is last pixel of video packet
//  width_out           out  16       active width from last complete control packet
//  height_out          out  16       active height
//  interlaced_out      out  4        interlace nibble
//  vip_ctrl_valid_out  out  1        1-cycle strobe: width/height/interlaced updated
// BEHAVIOUR
//  Reset: stall=1; data_out=0, end_of_video=0, width/height/interlaced=0, vip_ctrl_valid_out=0; FSM=IDLE.
//  Input beat accepted when din_valid & din_ready. Core transfer occurs when read & ~stall.
//  FSM states: IDLE, CTRL, VIDEO, DISCARD.
//  - IDLE: din_ready=1. Beats without sop ignored. Sop beat = header; type = symbol0[3:0].
//    - type 0x0 -> VIDEO; type 0xF -> CTRL; other -> DISCARD.
//    - header beat with eop also set -> stay IDLE, no output.
//  - A sop beat in any state aborts the current packet and is decoded as a new header.
//    No synthetic end_of_video; partial control data discarded.
//  - CTRL: din_ready=1. Nibble n (0..8) = symbol[3:0]; n = beat_idx*S + symbol_idx.
//    - Order: W[15:12],W[11:8],W[7:4],W[3:0],H[15:12],H[11:8],H[7:4],H[3:0],I[3:0].
//    - Beats past ceil(9/S) ignored; nibbles in shadow regs.
//    - On eop: if all 9 nibbles received, next cycle copy shadows to outputs and pulse
//      vip_ctrl_valid_out for 1 cycle; else no update, no pulse. Go to IDLE.
//  - VIDEO: every non-header beat is one pixel. Single output register (valid = ~stall).
//    - din_ready = stall | read (register empty or being drained this cycle).
//    - Accepted beat -> data_out/end_of_video (= din_endofpacket) next cycle, stall=0.
//    - Latency 1 cycle.
//    - Register held stable while stall=0 & read=0; simultaneous drain+fill = no bubble.
//    - Register drained with no new beat -> stall=1 next cycle.
//    - eop beat accepted -> IDLE.
//  - DISCARD: din_ready=1, consume until eop -> IDLE.
//  - Header/control beats never reach the core. Pending pixel still drains in IDLE/CTRL/DISCARD.
//  - width/height/interlaced hold until next complete control packet; unaffected by video.
//  - Mid-operation reset: all outputs return to reset values immediately; pending pixel lost.
// TESTING
//  1. Ctrl pkt S=3: 24'h00000F(sop), 24'h080200, 24'h010000, 24'h00000E(eop)
//     -> width_out=640, height_out=480, interlaced_out=0; vip_ctrl_valid_out 1 cycle after eop.
//  2. Truncated ctrl: header + 24'h080200(eop) -> no strobe; width/height keep prior values.
//  3. Video pkt: header 24'h000000, pixels 24'h112233, 24'h445566(eop), read=1
//     -> data_out 24'h112233 then 24'h445566 with end_of_video=1; stall=1 after.
//  4. Backpressure: read=0 for 5 cycles mid-video -> din_ready=0 while register full;
//     data_out stable; no pixel lost or duplicated; read=1 resumes 1 pixel/cycle.
//  5. Type 0x3 packet of 4 beats then video -> no pixels/strobe from 0x3; video decoded normally.
//  6. Sop during VIDEO after 2 pixels, new header 0xF -> video abandoned; control decoded;
//     rst pulse mid-video -> stall=1, all outputs 0.

Source files
------------

// File: rtl/vip_stream_decoder.sv
// Avalon-ST Video sink front-end: decodes control packets into width/height/interlace
// fields and forwards video packet pixels to a core through a stall/read handshake.
module vip_stream_decoder #(
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        din_valid,
    input  logic                                        din_startofpacket,
    input  logic                                        din_endofpacket,
    output logic                                        din_ready,
    input  logic                                        read,
    output logic                                        stall,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
    output logic                                        end_of_video,
    output logic [15:0]                                 width_out,
    output logic [15:0]                                 height_out,
    output logic [3:0]                                  interlaced_out,
    output logic                                        vip_ctrl_valid_out
);

    typedef enum logic [1:0] {StIdle, StCtrl, StVideo, StDiscard} state_t;

    state_t           state_q;
    logic [3:0]       nib_idx_q;   // next control nibble index, saturates at 9
    logic [8:0][3:0]  shadow_q;    // control nibbles in arrival order
    logic [8:0][3:0]  shadow_d;
    logic [3:0]       nib_next;
    logic             nib_full;
    logic             beat_acc;

    // In VIDEO the output register must be empty or draining to take a pixel.
    assign din_ready = (state_q == StVideo) ? (stall | read) : 1'b1;
    assign beat_acc  = din_valid & din_ready;

    // Merge the nibbles of the current beat into the shadow copy.
    always_comb begin
        shadow_d = shadow_q;
        for (int s = 0; s < int'(SYMBOLS_PER_BEAT); s++) begin
            int idx;
            idx = int'(nib_idx_q) + s;
            if (idx < 9) begin
                shadow_d[idx[3:0]] = din_data[s*int'(BITS_PER_SYMBOL) +: 4];
            end
        end
        nib_full = (int'(nib_idx_q) + int'(SYMBOLS_PER_BEAT)) >= 9;
        nib_next = nib_full ? 4'd9 : nib_idx_q + 4'(SYMBOLS_PER_BEAT);
    end

    // Packet FSM with registered pixel and control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= StIdle;
            nib_idx_q          <= 4'd0;
            shadow_q           <= '0;
            stall              <= 1'b1;
            data_out           <= '0;
            end_of_video       <= 1'b0;
            width_out          <= 16'd0;
            height_out         <= 16'd0;
            interlaced_out     <= 4'd0;
            vip_ctrl_valid_out <= 1'b0;
        end else begin
            vip_ctrl_valid_out <= 1'b0;
            // Drain first; a simultaneous fill below overrides, giving no bubble.
            if (read && !stall) begin
                stall <= 1'b1;
            end
            if (beat_acc) begin
                if (din_startofpacket) begin
                    nib_idx_q <= 4'd0;
                    if (din_endofpacket) begin
                        state_q <= StIdle;
                    end else begin
                        case (din_data[3:0])
                            4'h0:    state_q <= StVideo;
                            4'hF:    state_q <= StCtrl;
                            default: state_q <= StDiscard;
                        endcase
                    end
                end else begin
                    unique case (state_q)
                        StIdle: begin
                        end
                        StCtrl: begin
                            shadow_q  <= shadow_d;
                            nib_idx_q <= nib_next;
                            if (din_endofpacket) begin
                                if (nib_full) begin
                                    width_out          <= {shadow_d[0], shadow_d[1],
                                                           shadow_d[2], shadow_d[3]};
                                    height_out         <= {shadow_d[4], shadow_d[5],
                                                           shadow_d[6], shadow_d[7]};
                                    interlaced_out     <= shadow_d[8];
                                    vip_ctrl_valid_out <= 1'b1;
                                end
                                state_q <= StIdle;
                            end
                        end
                        StVideo: begin
                            data_out     <= din_data;
                            end_of_video <= din_endofpacket;
                            stall        <= 1'b0;
                            if (din_endofpacket) begin
                                state_q <= StIdle;
                            end
                        end
                        StDiscard: begin
                            if (din_endofpacket) begin
                                state_q <= StIdle;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule
